phase_seq_monitor: RTL and testbench

- Receiving end of the four-phase one-hot strobe rotation produced by the clock divider.
- Samples the four phase strobes each clock, acquires lock on the ph1→ph2→ph3→ph4→ph1 order, and reports the current phase index.
- Flags and counts sequence violations and counts completed rotations.
- Sits beside the phase consumers so control logic can gate multi-program placement on a verified phase.

---
 rtl/phase_seq_monitor_if.sv | 30 +++
 rtl/phase_seq_monitor.sv | 142 ++++++++++++++
 tb/tb_phase_seq_monitor.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/phase_seq_monitor_if.sv
// Strobe inputs and status outputs of the phase sequence monitor.
// clk_in and rst_in stay plain ports on the module.
interface phase_seq_monitor_if #(
    parameter int unsigned ERR_W = 8,
    parameter int unsigned ROT_W = 16
);
    logic             ph1_in;
    logic             ph2_in;
    logic             ph3_in;
    logic             ph4_in;
    logic             cnt_clr;
    logic [1:0]       phase_idx;
    logic             phase_valid;
    logic             locked;
    logic             err_pulse;
    logic [ERR_W-1:0] err_count;
    logic [ROT_W-1:0] rot_count;

    // Divider / stimulus side
    modport master (
        output ph1_in, ph2_in, ph3_in, ph4_in, cnt_clr,
        input  phase_idx, phase_valid, locked, err_pulse, err_count, rot_count
    );

    // Monitor side
    modport slave (
        input  ph1_in, ph2_in, ph3_in, ph4_in, cnt_clr,
        output phase_idx, phase_valid, locked, err_pulse, err_count, rot_count
    );
endinterface

// File: rtl/phase_seq_monitor.sv
// Phase sequence monitor: locks onto the ph1->ph2->ph3->ph4 one-hot rotation,
// reports the current phase, and counts violations and completed rotations.
// ERR_W / ROT_W must match the parameters of the connected interface.
module phase_seq_monitor #(
    parameter int unsigned LOCK_ROT = 2,
    parameter int unsigned ERR_W    = 8,
    parameter int unsigned ROT_W    = 16
) (
    input logic                clk_in,
    input logic                rst_in,
    phase_seq_monitor_if.slave bus
);

    localparam int unsigned GoodTarget = 4 * LOCK_ROT;
    localparam int unsigned GoodW      = $clog2(GoodTarget + 1);

    typedef enum logic [1:0] {StSearch, StAcq, StLock} state_e;

    state_e             state_q, state_d;
    logic [1:0]         last_idx_q, last_idx_d;
    logic [GoodW-1:0]   good_cnt_q, good_cnt_d;
    logic               phase_valid_q, phase_valid_d;
    logic               err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0]   err_count_q, err_count_d;
    logic [ROT_W-1:0]   rot_count_q, rot_count_d;

    logic [3:0] p;
    logic       valid;
    logic [1:0] idx;
    logic [1:0] exp_idx;
    logic       in_order;

    assign p        = {bus.ph4_in, bus.ph3_in, bus.ph2_in, bus.ph1_in};
    assign exp_idx  = last_idx_q + 2'd1;
    assign in_order = valid && (idx == exp_idx);

    // Decode the sampled strobes into a one-hot valid flag and index
    always_comb begin
        valid = 1'b0;
        idx   = 2'd0;
        unique case (p)
            4'b0001: begin valid = 1'b1; idx = 2'd0; end
            4'b0010: begin valid = 1'b1; idx = 2'd1; end
            4'b0100: begin valid = 1'b1; idx = 2'd2; end
            4'b1000: begin valid = 1'b1; idx = 2'd3; end
            default: begin valid = 1'b0; idx = 2'd0; end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q       <= StSearch;
            last_idx_q    <= 2'd0;
            good_cnt_q    <= '0;
            phase_valid_q <= 1'b0;
            err_pulse_q   <= 1'b0;
            err_count_q   <= '0;
            rot_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            last_idx_q    <= last_idx_d;
            good_cnt_q    <= good_cnt_d;
            phase_valid_q <= phase_valid_d;
            err_pulse_q   <= err_pulse_d;
            err_count_q   <= err_count_d;
            rot_count_q   <= rot_count_d;
        end
    end

    // Next-state: acquisition run length, last index, lock transitions
    always_comb begin
        state_d    = state_q;
        last_idx_d = last_idx_q;
        good_cnt_d = good_cnt_q;
        unique case (state_q)
            StSearch: begin
                if (valid) begin
                    last_idx_d = idx;
                    good_cnt_d = GoodW'(1);
                    state_d    = StAcq;
                end
            end
            StAcq: begin
                if (!valid) begin
                    good_cnt_d = '0;
                    state_d    = StSearch;
                end else if (in_order) begin
                    last_idx_d = idx;
                    good_cnt_d = good_cnt_q + GoodW'(1);
                    if (good_cnt_q + GoodW'(1) == GoodW'(GoodTarget)) begin
                        state_d = StLock;
                    end
                end else begin
                    // Out-of-order but clean strobe: restart the run from here
                    last_idx_d = idx;
                    good_cnt_d = GoodW'(1);
                end
            end
            StLock: begin
                if (in_order) begin
                    last_idx_d = idx;
                end else begin
                    // Violation keeps the last good index visible on phase_idx
                    good_cnt_d = '0;
                    state_d    = StSearch;
                end
            end
            default: begin
                good_cnt_d = '0;
                state_d    = StSearch;
            end
        endcase
    end

    // Output next values: phase_valid, err_pulse and the two counters
    always_comb begin
        phase_valid_d = in_order && (state_d == StLock);
        err_pulse_d   = (state_q == StLock) && !in_order;
        err_count_d   = err_count_q;
        rot_count_d   = rot_count_q;
        if (bus.cnt_clr) begin
            err_count_d = '0;
            rot_count_d = '0;
        end else begin
            if (err_pulse_d && (err_count_q != {ERR_W{1'b1}})) begin
                err_count_d = err_count_q + ERR_W'(1);
            end
            if ((state_q == StLock) && in_order && (last_idx_q == 2'd3)) begin
                rot_count_d = rot_count_q + ROT_W'(1);
            end
        end
    end

    assign bus.phase_idx   = last_idx_q;
    assign bus.phase_valid = phase_valid_q;
    assign bus.locked      = (state_q == StLock);
    assign bus.err_pulse   = err_pulse_q;
    assign bus.err_count   = err_count_q;
    assign bus.rot_count   = rot_count_q;

endmodule

// File: tb/tb_phase_seq_monitor.sv
// Randomized + directed bench for phase_seq_monitor against a run-length model.
module tb_phase_seq_monitor;

    localparam int unsigned LOCK_ROT = 2;
    localparam int unsigned ERR_W    = 8;
    localparam int unsigned ROT_W    = 16;
    localparam int          NEED     = 4 * LOCK_ROT;
    localparam int          ERR_MAX  = (1 << ERR_W) - 1;
    localparam int          ROT_MOD  = 1 << ROT_W;

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;

    phase_seq_monitor_if #(.ERR_W(ERR_W), .ROT_W(ROT_W)) bus ();

    phase_seq_monitor #(
        .LOCK_ROT (LOCK_ROT),
        .ERR_W    (ERR_W),
        .ROT_W    (ROT_W)
    ) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: length of the current in-order run, lock flag, counters
    int m_run, m_last, m_locked, m_pv, m_ep, m_err, m_rot;
    int gen;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_last = 0; m_locked = 0; m_pv = 0; m_ep = 0; m_err = 0; m_rot = 0;
    endtask

    task automatic model_step(input logic [3:0] p, input bit clr);
        bit v;
        bit err_ev;
        bit rot_ev;
        int idx;
        int nxt;
        v      = ($countones(p) == 1);
        idx    = 0;
        err_ev = 0;
        rot_ev = 0;
        for (int i = 0; i < 4; i++) if (p[i]) idx = i;
        nxt  = (m_last + 1) % 4;
        m_pv = 0;
        m_ep = 0;
        if (m_locked != 0) begin
            if (v && idx == nxt) begin
                m_pv   = 1;
                rot_ev = (idx == 0);
                m_last = idx;
            end else begin
                m_ep     = 1;
                err_ev   = 1;
                m_locked = 0;
                m_run    = 0;
            end
        end else if (!v) begin
            m_run = 0;
        end else begin
            if (m_run > 0 && idx == nxt) m_run++;
            else m_run = 1;
            m_last = idx;
            if (m_run == NEED) begin
                m_locked = 1;
                m_pv     = 1;
            end
        end
        if (clr) begin
            m_err = 0;
            m_rot = 0;
        end else begin
            if (err_ev && m_err < ERR_MAX) m_err++;
            if (rot_ev) m_rot = (m_rot + 1) % ROT_MOD;
        end
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".locked"},      32'(bus.locked),      32'(m_locked));
        check_eq({tag, ".phase_idx"},   32'(bus.phase_idx),   32'(m_last));
        check_eq({tag, ".phase_valid"}, 32'(bus.phase_valid), 32'(m_pv));
        check_eq({tag, ".err_pulse"},   32'(bus.err_pulse),   32'(m_ep));
        check_eq({tag, ".err_count"},   32'(bus.err_count),   32'(m_err));
        check_eq({tag, ".rot_count"},   32'(bus.rot_count),   32'(m_rot));
    endtask

    task automatic drive(input logic [3:0] p, input bit clr, input string tag);
        @(negedge clk_in);
        {bus.ph4_in, bus.ph3_in, bus.ph2_in, bus.ph1_in} = p;
        bus.cnt_clr = clr;
        @(posedge clk_in);
        model_step(p, clr);
        #1;
        check_all(tag);
    endtask

    // n in-order strobes continuing from gen
    task automatic rotate(input int n, input string tag);
        logic [3:0] p;
        for (int i = 0; i < n; i++) begin
            p = 4'b0001 << gen;
            drive(p, 1'b0, tag);
            gen = (gen + 1) % 4;
        end
    endtask

    initial begin
        logic [3:0] p;
        int r;
        bus.ph1_in = 0; bus.ph2_in = 0; bus.ph3_in = 0; bus.ph4_in = 0; bus.cnt_clr = 0;
        model_reset();
        gen = 0;
        repeat (2) @(posedge clk_in);
        #1 check_all("reset");
        @(negedge clk_in) rst_in = 1'b1;

        // Basic lock: 7 samples not locked, 8th locks, then one wrap counts a rotation
        rotate(NEED, "acquire");
        check_eq("lock_after_8", 32'(bus.locked), 32'd1);
        rotate(1, "first_wrap");
        check_eq("rot_after_wrap", 32'(bus.rot_count), 32'd1);
        rotate(3, "locked_run");

        // Skip ph3 while locked
        gen = 0;
        rotate(2, "pre_skip");
        gen = 3;
        rotate(1, "skip_ph3");
        check_eq("skip_err_count", 32'(bus.err_count), 32'd1);
        rotate(NEED, "relock1");

        // Multi-hot then zero strobes, each after a re-lock
        drive(4'b0011, 1'b0, "multi_hot");
        rotate(NEED, "relock2");
        drive(4'b0000, 1'b0, "no_strobe");
        check_eq("two_more_errs", 32'(bus.err_count), 32'd3);

        // ACQ restart at run 5 with an out-of-order ph1
        gen = 1;
        rotate(5, "acq_run5");
        gen = 0;
        rotate(1, "acq_restart");
        rotate(NEED - 1, "acq_after_restart");
        check_eq("lock_after_restart", 32'(bus.locked), 32'd1);

        // Saturation: 300 violations, then cnt_clr on a violating edge
        for (int k = 0; k < 300; k++) begin
            rotate(NEED, "sat_lock");
            drive(4'b0000, 1'b0, "sat_viol");
        end
        check_eq("err_saturated", 32'(bus.err_count), 32'(ERR_MAX));
        rotate(NEED, "clr_lock");
        drive(4'b0000, 1'b1, "clr_viol");
        check_eq("clr_pulse", 32'(bus.err_pulse), 32'd1);
        check_eq("clr_count", 32'(bus.err_count), 32'd0);

        // Randomized mix of clean rotation, stray one-hots, garbage and clears
        for (int k = 0; k < 3000; k++) begin
            r = $urandom_range(0, 99);
            if (r < 85) begin
                p   = 4'b0001 << gen;
                gen = (gen + 1) % 4;
            end else if (r < 93) begin
                gen = $urandom_range(0, 3);
                p   = 4'b0001 << gen;
                gen = (gen + 1) % 4;
            end else begin
                p = 4'($urandom_range(0, 15));
            end
            drive(p, ($urandom_range(0, 99) < 3), "random");
        end

        // Asynchronous reset mid-lock
        rotate(NEED + 2, "pre_async");
        @(posedge clk_in);
        #3 rst_in = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        @(negedge clk_in) rst_in = 1'b1;
        gen = 2;
        rotate(NEED - 1, "reacq");
        check_eq("no_early_lock", 32'(bus.locked), 32'd0);
        rotate(1, "reacq_last");
        check_eq("relock_after_reset", 32'(bus.locked), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
